psum_pack: RTL

Output back end of the MAC datapath: consumes the signed `psum_bw`-bit partial-sum stream produced by the 4-way `mac` array and converts it back into the unsigned `bw`-bit activation format that the array accepts as `a0..a3`. Each psum is passed through ReLU, a right shift and unsigned saturation, then four results are packed into one activation word. Words are presented on a valid/ready output register to the activation buffer writer for the next layer.

---
 rtl/psum_pack_pkg.sv | 7 +
 rtl/psum_quant.sv | 32 +++
 rtl/psum_pack.sv | 105 ++++++++++
 3 files changed

// File: rtl/psum_pack_pkg.sv
// Shared constants for the psum_pack output back end; defaults match the 4-way mac array.
package psum_pack_pkg;
  localparam int unsigned BW      = 4;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned LANES   = 4;
  localparam int unsigned ACT_MAX = 2**BW - 1;
endpackage

// File: rtl/psum_quant.sv
// Combinational psum quantizer: ReLU, optional round half-up, right shift, unsigned saturation.
// Build option: PSUM_PACK_ROUND_EN selects round half-up before the shift.
module psum_quant
  import psum_pack_pkg::*;
#(
  parameter int unsigned bw      = BW,
  parameter int unsigned psum_bw = PSUM_BW
) (
  input  logic signed [psum_bw-1:0] in_psum,
  input  logic        [3:0]         shift,
  output logic        [bw-1:0]      q
);
  localparam int unsigned      XW   = psum_bw + 1;
  localparam logic [XW-1:0]    QMAX = XW'((64'd1 << bw) - 64'd1);

  logic [XW-1:0] mag;
  logic [XW-1:0] rnd;
  logic [XW-1:0] shifted;

  // One guard bit above psum_bw keeps mag + rnd from overflowing.
  always_comb begin
    mag = {1'b0, in_psum};
    rnd = '0;
`ifdef PSUM_PACK_ROUND_EN
    if (shift != 4'd0) rnd = XW'(1) << (shift - 4'd1);
`endif
    shifted = (mag + rnd) >> shift;
    if (in_psum[psum_bw-1])  q = '0;
    else if (shifted > QMAX) q = '1;
    else                     q = shifted[bw-1:0];
  end
endmodule

// File: rtl/psum_pack.sv
// Packs quantized psums into lanes-wide activation words behind a valid/ready output register.
// Build option: PSUM_PACK_ROUND_EN (round half-up in psum_quant); handshake identical either way.
module psum_pack
  import psum_pack_pkg::*;
#(
  parameter int unsigned bw      = BW,
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned lanes   = LANES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [psum_bw-1:0] in_psum,
  input  logic                      in_last,
  input  logic        [3:0]         shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lanes*bw-1:0]       out_data,
  output logic [lanes-1:0]          out_mask
);
  localparam int unsigned IW = (lanes > 1) ? $clog2(lanes) : 1;

  logic [IW-1:0]         idx_q,       idx_d;
  logic [lanes*bw-1:0]   pack_data_q, pack_data_d;
  logic [lanes-1:0]      pack_mask_q, pack_mask_d;
  logic [lanes*bw-1:0]   out_data_q,  out_data_d;
  logic [lanes-1:0]      out_mask_q,  out_mask_d;
  logic                  out_valid_q, out_valid_d;

  logic [bw-1:0]         q;
  logic                  accept;
  logic                  complete;
  logic [lanes*bw-1:0]   word_data;
  logic [lanes-1:0]      word_mask;

  psum_quant #(
    .bw      (bw),
    .psum_bw (psum_bw)
  ) u_quant (
    .in_psum (in_psum),
    .shift   (shift),
    .q       (q)
  );

  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    word_data = pack_data_q;
    word_mask = pack_mask_q;
    for (int unsigned i = 0; i < lanes; i++) begin
      if (idx_q == IW'(i)) begin
        word_data[i*bw +: bw] = q;
        word_mask[i]          = 1'b1;
      end
    end
    complete = accept && ((idx_q == IW'(lanes - 1)) || in_last);

    idx_d       = idx_q;
    pack_data_d = pack_data_q;
    pack_mask_d = pack_mask_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // A completing beat reloads the output even while the old word drains.
    if (complete) begin
      out_data_d  = word_data;
      out_mask_d  = word_mask;
      out_valid_d = 1'b1;
      idx_d       = '0;
      pack_data_d = '0;
      pack_mask_d = '0;
    end else if (accept) begin
      pack_data_d = word_data;
      pack_mask_d = word_mask;
      idx_d       = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      pack_data_q <= '0;
      pack_mask_q <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      pack_data_q <= pack_data_d;
      pack_mask_q <= pack_mask_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
endmodule
